// File: rtl/config_sequencer.sv
// config_sequencer: queues host (addr, data, last) words and replays each one as a
// single-cycle config bus write. Optional parity check: define CONFIG_SEQ_PARITY_EN.
module config_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  input  logic        in_last,
`ifdef CONFIG_SEQ_PARITY_EN
  input  logic        in_parity,
  output logic [7:0]  err_count,
`endif
  output logic [31:0] config_addr,
  output logic [31:0] config_data,
  output logic        config_write,
  output logic        busy,
  output logic        done,
  output logic [15:0] word_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [3:0]    hold_cnt_reg, hold_cnt_next;
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [64:0]   fifo_mem [FIFO_DEPTH];
  logic [31:0]   config_addr_reg, config_data_reg;
  logic          config_write_reg, cur_last_reg, done_reg;
  logic [15:0]   word_count_reg;
  logic          accept, push, pop, load, words_left;

  assign in_ready = (count_reg < CW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;

`ifdef CONFIG_SEQ_PARITY_EN
  logic       parity_ok;
  logic [7:0] err_count_reg;

  // A bad-parity word completes its handshake but is discarded here.
  assign parity_ok = (in_parity == ^{in_addr, in_data});
  assign push      = accept && parity_ok;
  assign err_count = err_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_reg <= '0;
    end else if (accept && !parity_ok && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end
`else
  assign push = accept;
`endif

  // Pop only happens with a word in flight, so count_reg >= 1 here.
  assign words_left = (count_reg > CW'(1)) || push;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= {in_last, in_addr, in_data};
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CW'(1);
    end else if (pop && !push) begin
      count_next = count_reg - CW'(1);
    end
  end

  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    pop           = 1'b0;
    load          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) state_next = SETUP;
      end
      SETUP: begin
        load       = 1'b1;
        state_next = STROBE;
      end
      STROBE: begin
        if (HOLD_CYCLES > 0) begin
          state_next    = HOLD;
          hold_cnt_next = '0;
        end else begin
          pop        = 1'b1;
          state_next = words_left ? SETUP : IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt_reg == 4'(HOLD_CYCLES - 1)) begin
          pop        = 1'b1;
          state_next = words_left ? SETUP : IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= IDLE;
      hold_cnt_reg     <= '0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      config_addr_reg  <= '0;
      config_data_reg  <= '0;
      config_write_reg <= 1'b0;
      cur_last_reg     <= 1'b0;
      done_reg         <= 1'b0;
      word_count_reg   <= '0;
    end else begin
      state_reg        <= state_next;
      hold_cnt_reg     <= hold_cnt_next;
      count_reg        <= count_next;
      config_write_reg <= load;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (load) begin
        {cur_last_reg, config_addr_reg, config_data_reg} <= fifo_mem[rd_ptr_reg];
      end
      if (pop) word_count_reg <= word_count_reg + 16'd1;
      // Setting on a last-word pop takes priority over clearing on a new accept.
      if (pop && cur_last_reg) begin
        done_reg <= 1'b1;
      end else if (push) begin
        done_reg <= 1'b0;
      end
    end
  end

  assign config_addr  = config_addr_reg;
  assign config_data  = config_data_reg;
  assign config_write = config_write_reg;
  assign done         = done_reg;
  assign word_count   = word_count_reg;
  assign busy         = (count_reg != '0) || (state_reg != IDLE);

endmodule

// File: tb/tb_config_sequencer.sv
// Directed self-checking bench for config_sequencer: one instance with HOLD_CYCLES=1
// and one with HOLD_CYCLES=0; parity scenario runs when CONFIG_SEQ_PARITY_EN is defined.
module tb_config_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid, in_ready, in_last;
  logic [31:0] in_addr, in_data, config_addr, config_data;
  logic        config_write, busy, done;
  logic [15:0] word_count;
  logic        in_valid0, in_ready0, in_last0;
  logic [31:0] in_addr0, in_data0, config_addr0, config_data0;
  logic        config_write0, busy0, done0;
  logic [15:0] word_count0;
`ifdef CONFIG_SEQ_PARITY_EN
  logic        in_parity, in_parity0;
  logic [7:0]  err_count, err_count0;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  config_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .in_last(in_last),
`ifdef CONFIG_SEQ_PARITY_EN
    .in_parity(in_parity), .err_count(err_count),
`endif
    .config_addr(config_addr), .config_data(config_data), .config_write(config_write),
    .busy(busy), .done(done), .word_count(word_count)
  );

  config_sequencer #(.FIFO_DEPTH(4), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_addr(in_addr0), .in_data(in_data0), .in_last(in_last0),
`ifdef CONFIG_SEQ_PARITY_EN
    .in_parity(in_parity0), .err_count(err_count0),
`endif
    .config_addr(config_addr0), .config_data(config_data0), .config_write(config_write0),
    .busy(busy0), .done(done0), .word_count(word_count0)
  );

  // Strobe monitor samples 2 time units after each rising edge.
  int cyc = 0;
  logic [31:0] s_addr[$];
  logic [31:0] s_data[$];
  int          s_cyc[$];
  logic [31:0] s0_addr[$];
  int          s0_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    if (config_write === 1'b1) begin
      s_addr.push_back(config_addr);
      s_data.push_back(config_data);
      s_cyc.push_back(cyc);
    end
    if (config_write0 === 1'b1) begin
      s0_addr.push_back(config_addr0);
      s0_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic l);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    in_last  = l;
`ifdef CONFIG_SEQ_PARITY_EN
    in_parity = ^{a, d};
`endif
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [31:0] d, input logic l);
    in_valid0 = v;
    in_addr0  = a;
    in_data0  = d;
    in_last0  = l;
`ifdef CONFIG_SEQ_PARITY_EN
    in_parity0 = ^{a, d};
`endif
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    drive0(1'b0, '0, '0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    s_addr.delete(); s_data.delete(); s_cyc.delete();
    s0_addr.delete(); s0_cyc.delete();
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    chk("reset_config_write", {31'd0, config_write}, 32'd0);
    chk("reset_config_addr", config_addr, 32'd0);
    chk("reset_config_data", config_data, 32'd0);
    chk("reset_word_count", {16'd0, word_count}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    $display("reset: in_ready=%0d busy=%0d word_count=%0d", in_ready, busy, word_count);
  endtask

  task automatic test_single_write();
    apply_reset();
    drive(1'b1, 32'h0001_0001, 32'hA5A5_A5A5, 1'b1);
    chk("single_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("single_no_early_strobe", {31'd0, config_write}, 32'd0);
    @(negedge clk);
    chk("single_strobe", {31'd0, config_write}, 32'd1);
    chk("single_addr", config_addr, 32'h0001_0001);
    chk("single_data", config_data, 32'hA5A5_A5A5);
    @(negedge clk);
    chk("single_strobe_one_cycle", {31'd0, config_write}, 32'd0);
    @(negedge clk);
    chk("single_word_count", {16'd0, word_count}, 32'd1);
    chk("single_done", {31'd0, done}, 32'd1);
    chk("single_busy", {31'd0, busy}, 32'd0);
    chk("single_strobe_total", s_addr.size(), 32'd1);
    $display("single: strobes=%0d word_count=%0d done=%0d", s_addr.size(), word_count, done);
    // next accepted word clears done
    @(negedge clk);
    drive(1'b1, 32'h0002_0003, 32'h1234_5678, 1'b0);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("done_cleared_on_accept", {31'd0, done}, 32'd0);
    repeat (4) @(negedge clk);
    chk("done_stays_clear", {31'd0, done}, 32'd0);
    chk("second_word_count", {16'd0, word_count}, 32'd2);
    $display("done_clear: done=%0d word_count=%0d", done, word_count);
  endtask

  task automatic test_back_to_back();
    int idx = 0;
    int guard = 0;
    int first_drop = -1;
    logic acc;
    apply_reset();
    while (idx < 10 && guard < 100) begin
      @(negedge clk);
      drive(1'b1, 32'h0010_0000 + idx, 32'hC000_0000 + idx, idx == 9);
      if (!in_ready && first_drop < 0) first_drop = idx;
      acc = in_ready;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    @(negedge clk); in_valid = 1'b0;
    chk("b2b_all_accepted", idx, 32'd10);
    chk("b2b_ready_drop_at_4", first_drop, 32'd4);
    for (int w = 0; w < 80 && s_addr.size() < 10; w++) @(negedge clk);
    repeat (6) @(negedge clk);
    chk("b2b_strobe_count", s_addr.size(), 32'd10);
    for (int i = 0; i < 10 && i < s_addr.size(); i++) begin
      chk($sformatf("b2b_addr_%0d", i), s_addr[i], 32'h0010_0000 + i);
      chk($sformatf("b2b_data_%0d", i), s_data[i], 32'hC000_0000 + i);
      if (i > 0) chk($sformatf("b2b_spacing_%0d", i), s_cyc[i] - s_cyc[i-1], 32'd3);
      $display("b2b: strobe %0d addr=0x%08h data=0x%08h cyc=%0d", i, s_addr[i], s_data[i], s_cyc[i]);
    end
    chk("b2b_word_count", {16'd0, word_count}, 32'd10);
    chk("b2b_done", {31'd0, done}, 32'd1);
    chk("b2b_busy_end", {31'd0, busy}, 32'd0);
  endtask

  task automatic test_push_on_pop();
    apply_reset();
    drive(1'b1, 32'h0003_0001, 32'h0000_00AA, 1'b0);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pop_push_first_strobe", {31'd0, config_write}, 32'd1);
    @(negedge clk);
    drive(1'b1, 32'h0003_0002, 32'h0000_00BB, 1'b1);
    chk("pop_push_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("pop_push_busy", {31'd0, busy}, 32'd1);
    chk("pop_push_addr_held", config_addr, 32'h0003_0001);
    @(negedge clk);
    chk("pop_push_second_strobe", {31'd0, config_write}, 32'd1);
    chk("pop_push_second_addr", config_addr, 32'h0003_0002);
    repeat (3) @(negedge clk);
    chk("pop_push_strobes", s_cyc.size(), 32'd2);
    if (s_cyc.size() >= 2) chk("pop_push_no_idle_gap", s_cyc[1] - s_cyc[0], 32'd3);
    $display("pop_push: strobes=%0d word_count=%0d", s_cyc.size(), word_count);
  endtask

  task automatic test_reset_mid_strobe();
    int n_before;
    apply_reset();
    drive(1'b1, 32'h0004_0000, 32'h1111_1111, 1'b0);
    @(posedge clk);
    @(negedge clk); drive(1'b1, 32'h0004_0001, 32'h2222_2222, 1'b0);
    @(posedge clk);
    @(negedge clk); drive(1'b1, 32'h0004_0002, 32'h3333_3333, 1'b1);
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    chk("midrst_in_strobe", {31'd0, config_write}, 32'd1);
    n_before = s_addr.size();
    reset = 1'b0;
    #1;
    chk("midrst_strobe_drops", {31'd0, config_write}, 32'd0);
    chk("midrst_busy_drops", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("midrst_addr", config_addr, 32'd0);
    chk("midrst_data", config_data, 32'd0);
    chk("midrst_word_count", {16'd0, word_count}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_no_replay", s_addr.size(), n_before);
    $display("mid_reset: strobes=%0d busy=%0d in_ready=%0d", s_addr.size(), busy, in_ready);
  endtask

  task automatic test_hold_zero();
    apply_reset();
    drive0(1'b1, 32'h0005_0000, 32'h5555_0000, 1'b0);
    @(posedge clk);
    @(negedge clk); drive0(1'b1, 32'h0005_0001, 32'h5555_0001, 1'b1);
    @(posedge clk);
    @(negedge clk); in_valid0 = 1'b0;
    chk("h0_no_early_strobe", {31'd0, config_write0}, 32'd0);
    @(negedge clk);
    chk("h0_strobe_a", {31'd0, config_write0}, 32'd1);
    chk("h0_addr_a", config_addr0, 32'h0005_0000);
    @(negedge clk);
    chk("h0_gap", {31'd0, config_write0}, 32'd0);
    chk("h0_addr_a_held", config_addr0, 32'h0005_0000);
    @(negedge clk);
    chk("h0_strobe_b", {31'd0, config_write0}, 32'd1);
    chk("h0_addr_b", config_addr0, 32'h0005_0001);
    repeat (3) @(negedge clk);
    chk("h0_strobes", s0_cyc.size(), 32'd2);
    if (s0_cyc.size() >= 2) begin
      chk("h0_spacing", s0_cyc[1] - s0_cyc[0], 32'd2);
      chk("h0_mon_addr_a", s0_addr[0], 32'h0005_0000);
      chk("h0_mon_addr_b", s0_addr[1], 32'h0005_0001);
    end
    chk("h0_word_count", {16'd0, word_count0}, 32'd2);
    chk("h0_busy_end", {31'd0, busy0}, 32'd0);
    $display("hold0: strobes=%0d word_count=%0d", s0_cyc.size(), word_count0);
  endtask

`ifdef CONFIG_SEQ_PARITY_EN
  task automatic test_parity();
    int idx = 0;
    int guard = 0;
    logic acc;
    apply_reset();
    while (idx < 3 && guard < 20) begin
      @(negedge clk);
      drive(1'b1, 32'h0006_0000 + idx, 32'h7000_0000 + idx, idx == 1);
      if (idx == 1) in_parity = ~in_parity;
      acc = in_ready;
      @(posedge clk);
      if (acc) idx++;
      guard++;
    end
    @(negedge clk); in_valid = 1'b0;
    repeat (12) @(negedge clk);
    chk("par_strobes", s_addr.size(), 32'd2);
    if (s_addr.size() >= 2) begin
      chk("par_addr_0", s_addr[0], 32'h0006_0000);
      chk("par_addr_1", s_addr[1], 32'h0006_0002);
    end
    chk("par_err_count", {24'd0, err_count}, 32'd1);
    chk("par_word_count", {16'd0, word_count}, 32'd2);
    chk("par_done_ignored", {31'd0, done}, 32'd0);
    $display("parity: strobes=%0d err_count=%0d word_count=%0d", s_addr.size(), err_count, word_count);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    drive0(1'b0, '0, '0, 1'b0);
    test_reset();
    test_single_write();
    test_back_to_back();
    test_push_on_pop();
    test_reset_mid_strobe();
    test_hold_zero();
`ifdef CONFIG_SEQ_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/config_sequencer.md
# config_sequencer

Sequences configuration writes into the tile array. A host pushes (address, data) words through a valid/ready port. The block buffers them in a small FIFO and replays each one onto the shared `config_addr`/`config_data` bus with a single-cycle `config_write` strobe; the per-tile address matchers of the PE tiles sample the bus on that strobe. It sits between the host/boot interface and the array-wide config bus, and reports progress and completion.

## Interface
- `FIFO_DEPTH`, 4: buffered words; power of two, ≥2.
- `HOLD_CYCLES`, 1: cycles the address and data stay stable after the strobe; range 0..15.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  the block can accept a word.
- `in_addr`  in  32  target config address: [15:0] tile_id, [31:16] config_id.
- `in_data`  in  32  config payload.
- `in_last`  in  1  marks the final word of a configuration stream.
- `in_parity`  in  1  parity of the word; the port exists only with `CONFIG_SEQ_PARITY_EN`.
- `config_addr`  out  32  config bus address, registered.
- `config_data`  out  32  config bus data, registered.
- `config_write`  out  1  one-cycle write strobe.
- `busy`  out  1  high while the FIFO is non-empty or the FSM is not in IDLE.
- `done`  out  1  sticky flag: a word marked `in_last` has been issued.
- `word_count`  out  16  number of words issued since reset; wraps from 0xFFFF to 0.
- `err_count`  out  8  number of words dropped for parity; the port exists only with `CONFIG_SEQ_PARITY_EN`.

## Operation
- A word is accepted when `in_valid` and `in_ready` are both high at a clock edge. The accepted `{addr, data, last}` is written to the FIFO.
- `in_ready` = (FIFO count < `FIFO_DEPTH`). It is a pure function of the registered count, with no pop bypass. When the FIFO is full, `in_ready` is 0.
- A push and a pop on the same edge leave the count unchanged.
- The FSM has four states: IDLE, SETUP, STROBE, HOLD.
  - IDLE: moves to SETUP when the FIFO is non-empty.
  - SETUP: `config_addr`/`config_data` load the FIFO head; `config_write` = 0. Moves to STROBE.
  - STROBE: `config_write` = 1 for exactly this cycle. Moves to HOLD if `HOLD_CYCLES` > 0; otherwise it pops the word here.
  - HOLD: lasts `HOLD_CYCLES` cycles. Address and data are unchanged and `config_write` = 0. The pop happens on the last HOLD cycle.
- On the pop:
  - `word_count` increments.
  - If the popped word has `last` set, `done` is set.
  - The next state is SETUP if a word remains after the pop (including a word pushed on the same edge), otherwise IDLE.
- `done` is cleared on the edge that accepts the next host word. If that accept coincides with a last-word pop, set wins.
- In IDLE, `config_addr`/`config_data` hold their last issued values.

## Timing
- Reset (asynchronous, active-low) takes effect immediately:
  - FIFO emptied; FSM in IDLE.
  - `config_write`, `config_addr`, `config_data`, `word_count`, `err_count`, `done` and `busy` all 0.
  - `in_ready` = 1 after reset is released.
- Reset asserted in the middle of a write aborts the write; a strobe already in progress drops at once. Words in the FIFO are lost.
- Latency: word accepted at edge E0 → SETUP after E1 → `config_write` high in the cycle following E2.
- Throughput: one word per (2 + `HOLD_CYCLES`) cycles.
- When the FIFO is full, a host word presented is not accepted (`in_ready` = 0) and must be held until `in_ready` rises.

## Configuration
- Macro `CONFIG_SEQ_PARITY_EN`.
- Defined:
  - `in_parity` must equal the XOR of all bits of `in_addr` and `in_data`.
  - On a mismatch the handshake completes normally, but the word is not written to the FIFO. Its `in_last` is ignored and it does not clear `done`.
  - `err_count` increments and saturates at 255.
- Undefined: the `in_parity` and `err_count` ports and the check logic are absent. Every accepted word is queued.

## Test plan
- Single write 0x0001_0001 / 0xA5A5_A5A5 with `last` set, `HOLD_CYCLES` = 1 → exactly one `config_write` pulse, two cycles after the accept edge, with the matching addr/data. Then `word_count` = 1, `done` = 1, `busy` = 0.
- Back-to-back stream of 10 words with `in_valid` held high, `FIFO_DEPTH` = 4 → `in_ready` drops at 4 queued words. Ten strobes, spaced 3 cycles apart, in order; no word lost or duplicated; `word_count` = 10.
- Push on the same edge as the pop of the only queued word → FSM goes directly HOLD → SETUP, with no IDLE cycle.
- Reset pulled low during the STROBE cycle with 3 words queued → `config_write` drops immediately; after release all outputs are 0 and `in_ready` = 1.
- `HOLD_CYCLES` = 0 → two words strobed on cycles N and N+2; `config_addr` stable through each strobe cycle.
- Parity on (`CONFIG_SEQ_PARITY_EN`): 3 words, the middle one with a flipped parity bit → 2 strobes, `err_count` = 1, `word_count` = 2.
